// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared MULT/DIV units into HI/LO.
// Launches the selected unit, waits for its done, then writes HI/LO or raises a divide-by-zero or timeout pulse.
`default_nettype none

module muldiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mult_req,
  input  logic div_req,
  input  logic divisor_zero,
  input  logic mult_done,
  input  logic div_done,
  output logic mult_start,
  output logic div_start,
  output logic hilo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic busy,
  output logic div_zero_exc,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    EXC_DZ = 3'd4,
    EXC_TO = 3'd5
  } state_t;

  state_t        state, state_next;
  logic          op, op_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          sel_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      op    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      op    <= op_next;
      cnt   <= cnt_next;
    end
  end

  // Only the launched unit's done can complete the operation.
  assign sel_done = op ? div_done : mult_done;

  always_comb begin
    state_next = state;
    op_next    = op;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (mult_req) begin
          op_next    = 1'b0;
          state_next = START;
        end else if (div_req) begin
          if (divisor_zero) begin
            state_next = EXC_DZ;
          end else begin
            op_next    = 1'b1;
            state_next = START;
          end
        end
      end
      START: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt != CNT_MAX) cnt_next = cnt + CW'(1);
        if (sel_done)             state_next = WRITE;
        else if (cnt == CNT_LAST) state_next = EXC_TO;
      end
      WRITE:   state_next = IDLE;
      EXC_DZ:  state_next = IDLE;
      EXC_TO:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is a decode of registered state/op, never of inputs.
  assign mult_start   = (state == START) && !op;
  assign div_start    = (state == START) &&  op;
  assign hilo_sel     = op;
  assign hi_write     = (state == WRITE);
  assign lo_write     = (state == WRITE);
  assign busy         = (state != IDLE);
  assign div_zero_exc = (state == EXC_DZ);
  assign timeout_err  = (state == EXC_TO);

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the shared MULT/DIV resources that feed the HI and LO registers. It accepts one-cycle MULT or DIV requests from the main control unit and launches the selected unit. It waits for that unit's done, drives the HI/LO source select and the write enables, and flags divide-by-zero and timeout. It sits between the main control FSM and the mult/div units, and owns the select line of the HI and LO source muxes.

## Interface
- TIMEOUT, default 40: maximum cycles spent in WAIT before a timeout abort; must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- mult_req  in  1  one-cycle request to run MULT.
- div_req  in  1  one-cycle request to run DIV.
- divisor_zero  in  1  divisor == 0; sampled only together with div_req.
- mult_done  in  1  multiplier result valid.
- div_done  in  1  divider result valid.
- mult_start  out  1  one-cycle launch pulse to the multiplier.
- div_start  out  1  one-cycle launch pulse to the divider.
- hilo_sel  out  1  HI and LO mux select: 0 = multiplier, 1 = divider.
- hi_write  out  1  HI register write enable.
- lo_write  out  1  LO register write enable.
- busy  out  1  high whenever state ≠ IDLE; main control stalls on it.
- div_zero_exc  out  1  one-cycle divide-by-zero exception pulse.
- timeout_err  out  1  one-cycle pulse when the selected unit fails to finish.

## Operation
- States: IDLE, START, WAIT, WRITE, EXC_DZ, EXC_TO. Internal op bit: 0 = mult, 1 = div.
- IDLE transitions:
  - mult_req=1: op←0, go to START. mult_req has priority when both requests are high in the same cycle.
  - div_req=1 with divisor_zero=0: op←1, go to START.
  - div_req=1 with divisor_zero=1: go to EXC_DZ. op is not changed and no unit is launched.
- START: assert mult_start (op=0) or div_start (op=1) for exactly one cycle. Clear the counter and go to WAIT.
- WAIT:
  - Increment the counter each cycle.
  - The done of the selected unit (mult_done if op=0, div_done if op=1) moves the FSM to WRITE. The other unit's done is ignored.
  - If the counter equals TIMEOUT-1 and the selected done is low, go to EXC_TO.
  - If done and the timeout condition occur on the same edge, done wins and the FSM goes to WRITE.
- WRITE: hi_write=lo_write=1 for exactly one cycle, then go to IDLE.
- EXC_DZ: div_zero_exc=1 for one cycle, then go to IDLE. HI and LO are not written.
- EXC_TO: timeout_err=1 for one cycle, then go to IDLE. HI and LO are not written.
- mult_req and div_req are ignored in every state except IDLE; they are not queued.
- Done inputs are ignored outside WAIT, including a done that arrives during START.
- hilo_sel is registered and equals op in every state. It is stable through WAIT and WRITE and keeps its value after returning to IDLE.
- Counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset values (reset_n=0 at an edge): state=IDLE, op=0, counter=0. All outputs are 0, including hilo_sel=0 and busy=0.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. No write or exception pulse is emitted for the aborted operation.
- All outputs are decoded from registered state and op; there are no combinational paths from inputs to outputs.
- Example timeline, with the request sampled at edge E0:
  - Cycle after E0: start pulse high, busy high.
  - Selected done first sampled high at edge Ek (k ≥ 2): write enables high during the cycle after Ek.
  - busy falls after edge Ek+1.
- Minimum request-to-write latency is 3 edges. This occurs when done is sampled at E2, the first WAIT edge.
- Divide-by-zero: div_zero_exc high during the cycle after E0, busy high for that single cycle.
- Timeout: timeout_err rises TIMEOUT edges after entering WAIT.
- A new request is accepted on the first edge at which busy=0.

## Test plan
- Reset with reset_n=0 for 2 cycles while mult_req=1 → all outputs 0, no start pulse. Release reset → FSM idle.
- mult_req pulse; mult_done high on the 5th cycle of WAIT → mult_start one cycle, hilo_sel=0, hi_write=lo_write=1 for one cycle, busy high for exactly 7 cycles.
- div_req with divisor_zero=0, and a spurious mult_done during WAIT; div_done after 32 cycles → mult_done ignored, hilo_sel=1, single write pulse, no exception.
- div_req with divisor_zero=1 → div_zero_exc for one cycle, no div_start, no writes, busy for one cycle, hilo_sel unchanged.
- mult_req and div_req in the same cycle, with a second div_req during WAIT → only mult runs (hilo_sel=0). The second request is dropped.
- TIMEOUT=40 with no done → timeout_err pulse 40 edges after entering WAIT, no writes. Repeat with done on the 40th edge → write occurs and timeout_err stays 0. Assert reset_n=0 mid-WAIT → IDLE next cycle, no pulses.
